// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
// SPI mode-0 slave that emulates a serial flash READ (0x03) command. It
// oversamples the asynchronous SPI pins with the system clock and fetches
// the read data from a backing memory with a fixed 1-cycle latency.
// Streaming is unlimited, and the address wraps modulo 2^24.
//
// Optional feature macro: SPI_FLASH_RESPONDER_FAST_READ_EN
//   When defined, FAST_READ (0x0B) is also accepted. Eight dummy clocks
//   follow the address.
//
// Parameters:
//   SYNC_STAGES   synchronizer depth on sclk/csb/mosi (2..3)
// Ports:
//   clk           system clock (>= 8x sclk)
//   rst           synchronous active-high reset
//   sclk,csb,mosi asynchronous SPI inputs
//   miso, miso_oe serial read data and its output enable
//   mem_req       one-cycle memory read strobe
//   mem_addr      byte address for mem_req
//   mem_rdata     memory data, valid the cycle after mem_req
//   busy          transaction in progress
//   cmd_err       one-cycle pulse on an unsupported command
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_flash_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        csb,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        S_IGNORE = 3'd4,
        S_DUMMY  = 3'd5
`else
        S_IGNORE = 3'd4
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] csb_sync_q,  csb_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic        sclk_prev_q, sclk_prev_d;
    logic        csb_prev_q,  csb_prev_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        arm_q, arm_d;
    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [22:0] shift_in_q, shift_in_d;
    logic [7:0]  shift_out_q, shift_out_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic        mem_req_q, mem_req_d;
    logic        load_q, load_d;
    logic        miso_q, miso_d;
    logic        miso_oe_q, miso_oe_d;
    logic        busy_q, busy_d;
    logic        cmd_err_q, cmd_err_d;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    logic        fast_q, fast_d;
`endif

    logic        sclk_s, csb_s, mosi_s;
    logic        sclk_rise_s, sclk_fall_s, csb_rise_s, csb_fall_s;
    logic [7:0]  cmd_byte_s;
    logic [23:0] addr_word_s;

    // Edge detection on the synchronized pins and assembly of the received words
    always_comb begin
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        csb_s       = csb_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise_s = sclk_s & ~sclk_prev_q;
        sclk_fall_s = ~sclk_s & sclk_prev_q;
        csb_rise_s  = csb_s & ~csb_prev_q;
        csb_fall_s  = ~csb_s & csb_prev_q;
        cmd_byte_s  = {shift_in_q[6:0], mosi_s};
        addr_word_s = {shift_in_q, mosi_s};
    end

    // Synchronizer chains plus the post-reset arming logic. Reset presets
    // csb high, so a csb already held low would look like a fall. A fall is
    // accepted only after the chain holds real samples and has shown csb high.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], csb};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        csb_prev_d  = csb_s;
        if (flush_cnt_q == 2'd3) begin
            flush_cnt_d = 2'd3;
            arm_d       = arm_q | csb_s;
        end else begin
            flush_cnt_d = flush_cnt_q + 2'd1;
            arm_d       = arm_q;
        end
    end

    // Next-state and datapath logic. A csb rise overrides any sclk event.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = 1'b0;
        load_d      = mem_req_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        cmd_err_d   = 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        fast_d      = fast_q;
`endif
        // Memory data arrives the cycle after the strobe.
        if (load_q) begin
            shift_out_d = mem_rdata;
        end else begin
            shift_out_d = shift_out_q;
        end

        if (csb_rise_s && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            bit_cnt_d  = 5'd0;
            shift_in_d = 23'd0;
            miso_d     = 1'b0;
            miso_oe_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (csb_fall_s && arm_q) begin
                        state_d    = S_CMD;
                        bit_cnt_d  = 5'd0;
                        shift_in_d = 23'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CMD: begin
                    if (sclk_rise_s) begin
                        shift_in_d = {shift_in_q[21:0], mosi_s};
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            if (cmd_byte_s == 8'h03) begin
                                state_d = S_ADDR;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                                fast_d  = 1'b0;
                            end else if (cmd_byte_s == 8'h0B) begin
                                state_d = S_ADDR;
                                fast_d  = 1'b1;
`endif
                            end else begin
                                state_d   = S_IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        state_d = S_CMD;
                    end
                end
                S_ADDR: begin
                    if (sclk_rise_s) begin
                        shift_in_d = {shift_in_q[21:0], mosi_s};
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d  = 5'd0;
                            mem_addr_d = addr_word_s;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                            if (fast_q) begin
                                state_d = S_DUMMY;
                            end else begin
                                mem_req_d = 1'b1;
                                state_d   = S_DATA;
                            end
`else
                            mem_req_d = 1'b1;
                            state_d   = S_DATA;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        state_d = S_ADDR;
                    end
                end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                S_DUMMY: begin
                    if (sclk_rise_s) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            mem_req_d = 1'b1;
                            state_d   = S_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        state_d = S_DUMMY;
                    end
                end
`endif
                S_DATA: begin
                    // Rises count the bits the master has taken. After the last
                    // bit of a byte, prefetch the next byte in time for the next fall.
                    if (sclk_rise_s) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d  = 5'd0;
                            mem_addr_d = mem_addr_q + 24'd1;
                            mem_req_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else if (sclk_fall_s) begin
                        miso_d      = shift_out_q[7];
                        shift_out_d = {shift_out_q[6:0], 1'b0};
                        miso_oe_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_IGNORE: begin
                    state_d = S_IGNORE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            csb_sync_q  <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            sclk_prev_q <= 1'b0;
            csb_prev_q  <= 1'b1;
            flush_cnt_q <= 2'd0;
            arm_q       <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 5'd0;
            shift_in_q  <= 23'd0;
            shift_out_q <= 8'd0;
            mem_addr_q  <= 24'd0;
            mem_req_q   <= 1'b0;
            load_q      <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            fast_q      <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            csb_sync_q  <= csb_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            csb_prev_q  <= csb_prev_d;
            flush_cnt_q <= flush_cnt_d;
            arm_q       <= arm_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            load_q      <= load_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            fast_q      <= fast_d;
`endif
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// -----------------------------------------------------------------------------
// Directed testbench for spi_flash_responder. The bench acts as the SPI
// master (mode 0, sclk = clk/16). Its memory model returns addr[7:0] one
// cycle after each mem_req. Every step is issued on a falling clk edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rst, sclk, csb, mosi;
    logic        miso, miso_oe, mem_req, busy, cmd_err;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int err_cycles = 0;
    int oe_cycles = 0;
    logic bad_miso = 1'b0;
    logic [23:0] addr_log[$];

    spi_flash_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Memory model and activity monitors
    always @(posedge clk) begin
        if (mem_req) begin
            mem_rdata <= mem_addr[7:0];
            req_cnt   <= req_cnt + 1;
            addr_log.push_back(mem_addr);
        end
        if (cmd_err) err_cycles <= err_cycles + 1;
        if (miso_oe) oe_cycles <= oe_cycles + 1;
        if (!miso_oe && (miso !== 1'b0)) bad_miso <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        #80;
        sclk = 1'b1;
        r = miso;
        #80;
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic d;
        for (int i = 7; i >= 0; i--) spi_bit(v[i], d);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic d;
        for (int i = 23; i >= 0; i--) spi_bit(a[i], d);
    endtask

    task automatic recv_byte(output logic [7:0] v);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(1'b0, d);
            v[i] = d;
        end
    endtask

    task automatic cs_low();
        csb = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #80;
        csb = 1'b1;
        #100;
    endtask

    initial begin
        logic [7:0] b0, b1, b2, b3;
        logic d;
        int r0, e0, o0, i0;

        rst = 1'b1; sclk = 1'b0; csb = 1'b1; mosi = 1'b0;
        #30;
        check("rst_miso", miso, 1'b0);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, 24'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", cmd_err, 1'b0);
        rst = 1'b0;
        #100;

        // Read at 0x000010, three bytes
        r0 = req_cnt;
        cs_low();
        send_byte(8'h03);
        send_addr(24'h000010);
        recv_byte(b0);
        check("rd1_busy", busy, 1'b1);
        check("rd1_oe", miso_oe, 1'b1);
        recv_byte(b1);
        recv_byte(b2);
        cs_high();
        check("rd1_b0", b0, 8'h10);
        check("rd1_b1", b1, 8'h11);
        check("rd1_b2", b2, 8'h12);
        check("rd1_reqs", req_cnt - r0, 4);
        check("rd1_busy_end", busy, 1'b0);
        check("rd1_oe_end", miso_oe, 1'b0);

        // Address wrap at 0xFFFFFE
        i0 = addr_log.size();
        cs_low();
        send_byte(8'h03);
        send_addr(24'hFFFFFE);
        recv_byte(b0);
        recv_byte(b1);
        recv_byte(b2);
        recv_byte(b3);
        cs_high();
        check("wrap_nreq", addr_log.size() - i0, 5);
        if (addr_log.size() >= i0 + 4) begin
            check("wrap_a0", addr_log[i0],     24'hFFFFFE);
            check("wrap_a1", addr_log[i0 + 1], 24'hFFFFFF);
            check("wrap_a2", addr_log[i0 + 2], 24'h000000);
            check("wrap_a3", addr_log[i0 + 3], 24'h000001);
        end else begin
            check("wrap_log_len", addr_log.size() - i0, 4);
        end
        check("wrap_b0", b0, 8'hFE);
        check("wrap_b1", b1, 8'hFF);
        check("wrap_b2", b2, 8'h00);
        check("wrap_b3", b3, 8'h01);

        // Unsupported command 0x9F
        r0 = req_cnt; e0 = err_cycles; o0 = oe_cycles;
        cs_low();
        send_byte(8'h9F);
        send_byte(8'h00);
        send_byte(8'h00);
        check("bad_busy", busy, 1'b1);
        cs_high();
        check("bad_err_cycles", err_cycles - e0, 1);
        check("bad_oe", oe_cycles - o0, 0);
        check("bad_req", req_cnt - r0, 0);

        // Abort after 12 address bits, then a full read at 0x000005
        r0 = req_cnt;
        cs_low();
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) spi_bit(1'b1, d);
        cs_high();
        check("abort_req", req_cnt - r0, 0);
        check("abort_busy", busy, 1'b0);
        cs_low();
        send_byte(8'h03);
        send_addr(24'h000005);
        recv_byte(b0);
        recv_byte(b1);
        cs_high();
        check("abort_b0", b0, 8'h05);
        check("abort_b1", b1, 8'h06);

        // Reset during the second data byte with csb held low
        cs_low();
        send_byte(8'h03);
        send_addr(24'h000030);
        recv_byte(b0);
        check("mrst_b0", b0, 8'h30);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, d);
        rst = 1'b1;
        #20;
        check("mrst_miso", miso, 1'b0);
        check("mrst_oe", miso_oe, 1'b0);
        check("mrst_req", mem_req, 1'b0);
        check("mrst_addr", mem_addr, 24'h0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_err", cmd_err, 1'b0);
        rst = 1'b0;
        #50;
        r0 = req_cnt; o0 = oe_cycles;
        send_byte(8'h03);
        send_addr(24'h000000);
        check("mrst_idle_busy", busy, 1'b0);
        check("mrst_idle_req", req_cnt - r0, 0);
        check("mrst_idle_oe", oe_cycles - o0, 0);
        cs_high();
        cs_low();
        send_byte(8'h03);
        send_addr(24'h000020);
        recv_byte(b0);
        cs_high();
        check("mrst_next_b0", b0, 8'h20);

        // FAST_READ 0x0B at 0x000040
        e0 = err_cycles; o0 = oe_cycles;
        cs_low();
        send_byte(8'h0B);
        send_addr(24'h000040);
        send_byte(8'hA5);
        recv_byte(b0);
        recv_byte(b1);
        cs_high();
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        check("fast_b0", b0, 8'h40);
        check("fast_b1", b1, 8'h41);
        check("fast_err", err_cycles - e0, 0);
`else
        check("fast_err", err_cycles - e0, 1);
        check("fast_oe", oe_cycles - o0, 0);
`endif

        check("miso_zero_when_off", bad_miso, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
